// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl
// Sequencer for LVDS bit-error-rate sweeps on one transceiver channel.
// Walks the 16 IDSET_A / DRV_STR_A combinations, and for each one:
// applies the control word and pulses CLR_SEQ, waits SETTLE_CYC cycles,
// measures errors over WINDOW_CYC cycles, then records pass/fail and the best
// (lowest window error) setting.
//
// Ports:
//   CLK        system clock
//   RSTX       asynchronous active-low reset
//   START      one-cycle pulse, begins a sweep (honoured only when idle)
//   ABORT      one-cycle pulse, stops the sweep (wins over START)
//   BASE_CTRL  template control word for the stimulus block
//   ERR_THR    pass threshold on the window error count
//   RECV_CNT   free-running received-word count from the stimulus
//   ERR_CNT    cumulative error count from the stimulus
//   CTRL       registered control word to the stimulus
//   CLR_SEQ    one-cycle clear pulse, one per configuration
//   BUSY       high while a sweep runs
//   DONE       sticky completion flag, cleared by START or ABORT
//   CFG_IDX    configuration currently applied
//   PASS_MAP   bit i set when configuration i passed
//   BEST_IDX   configuration with the lowest window error count
//   BEST_ERR   window error count of BEST_IDX
module ber_sweep_ctrl #(
  parameter int SETTLE_CYC = 1024,
  parameter int WINDOW_CYC = 1048576,
  parameter int CNT_W      = 21
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        START,
  input  logic        ABORT,
  input  logic [30:0] BASE_CTRL,
  input  logic [15:0] ERR_THR,
  input  logic [57:0] RECV_CNT,
  input  logic [63:0] ERR_CNT,
  output logic [30:0] CTRL,
  output logic        CLR_SEQ,
  output logic        BUSY,
  output logic        DONE,
  output logic [3:0]  CFG_IDX,
  output logic [15:0] PASS_MAP,
  output logic [3:0]  BEST_IDX,
  output logic [63:0] BEST_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_MEASURE,
    S_EVAL
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [63:0]      err0_reg, err0_next;
  logic [57:0]      rcv0_reg, rcv0_next;
  logic [30:0]      ctrl_reg, ctrl_next;
  logic             clr_seq_reg, clr_seq_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [3:0]       cfg_idx_reg, cfg_idx_next;
  logic [15:0]      pass_map_reg, pass_map_next;
  logic [3:0]       best_idx_reg, best_idx_next;
  logic [63:0]      best_err_reg, best_err_next;

  logic        settle_end;
  logic        window_end;
  logic        link_dead;
  logic [63:0] werr;
  logic        cfg_pass;

  // Insert the configuration index into the template word:
  // idx[1:0] -> IDSET_A at [24:23], idx[3:2] -> DRV_STR_A at [18:17].
  function automatic logic [30:0] map_cfg(input logic [30:0] base,
                                          input logic [3:0]  idx);
    logic [30:0] w;
    w        = base;
    w[24:23] = idx[1:0];
    w[18:17] = idx[3:2];
    return w;
  endfunction

  assign settle_end = (cnt_reg == SETTLE_LAST);
  assign window_end = (cnt_reg == WINDOW_LAST);

  // Window error count. Modular subtraction absorbs a wrap of ERR_CNT inside
  // the window; an unchanged RECV_CNT means nothing was received, which is
  // treated as the worst possible result.
  assign link_dead = (RECV_CNT == rcv0_reg);
  assign werr      = link_dead ? {64{1'b1}} : (ERR_CNT - err0_reg);
  assign cfg_pass  = (werr <= {48'd0, ERR_THR});

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      err0_reg     <= '0;
      rcv0_reg     <= '0;
      ctrl_reg     <= '0;
      clr_seq_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cfg_idx_reg  <= '0;
      pass_map_reg <= '0;
      best_idx_reg <= '0;
      best_err_reg <= {64{1'b1}};
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      err0_reg     <= err0_next;
      rcv0_reg     <= rcv0_next;
      ctrl_reg     <= ctrl_next;
      clr_seq_reg  <= clr_seq_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      cfg_idx_reg  <= cfg_idx_next;
      pass_map_reg <= pass_map_next;
      best_idx_reg <= best_idx_next;
      best_err_reg <= best_err_next;
    end
  end

  // Next-state logic; ABORT overrides everything
  always_comb begin
    state_next = state_reg;
    if (ABORT) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (START) state_next = S_APPLY;
        S_APPLY:   state_next = S_SETTLE;
        S_SETTLE:  if (settle_end) state_next = S_MEASURE;
        S_MEASURE: if (window_end) state_next = S_EVAL;
        S_EVAL:    state_next = (cfg_idx_reg == 4'd15) ? S_IDLE : S_APPLY;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values. Outputs are computed from state_next so
  // that the registered outputs line up with the state they describe.
  always_comb begin
    cnt_next      = cnt_reg;
    err0_next     = err0_reg;
    rcv0_next     = rcv0_reg;
    done_next     = done_reg;
    cfg_idx_next  = cfg_idx_reg;
    pass_map_next = pass_map_reg;
    best_idx_next = best_idx_reg;
    best_err_next = best_err_reg;

    if (ABORT) begin
      // Partial results are kept on purpose so a stopped sweep can be read.
      done_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (START) begin
            cfg_idx_next  = '0;
            pass_map_next = '0;
            best_idx_next = '0;
            best_err_next = {64{1'b1}};
            done_next     = 1'b0;
          end
        end
        S_APPLY: cnt_next = '0;
        S_SETTLE: begin
          if (settle_end) begin
            cnt_next  = '0;
            err0_next = ERR_CNT;
            rcv0_next = RECV_CNT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        S_MEASURE: cnt_next = cnt_reg + CNT_W'(1);
        S_EVAL: begin
          pass_map_next[cfg_idx_reg] = cfg_pass;
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (werr < best_err_reg) begin
            best_err_next = werr;
            best_idx_next = cfg_idx_reg;
          end
          if (cfg_idx_reg == 4'd15) begin
            done_next = 1'b1;
          end else begin
            cfg_idx_next = cfg_idx_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end

    busy_next    = (state_next != S_IDLE);
    clr_seq_next = (state_next == S_APPLY);
    ctrl_next    = busy_next ? map_cfg(BASE_CTRL, cfg_idx_next) : BASE_CTRL;
  end

  assign CTRL     = ctrl_reg;
  assign CLR_SEQ  = clr_seq_reg;
  assign BUSY     = busy_reg;
  assign DONE     = done_reg;
  assign CFG_IDX  = cfg_idx_reg;
  assign PASS_MAP = pass_map_reg;
  assign BEST_IDX = best_idx_reg;
  assign BEST_ERR = best_err_reg;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb_ber_sweep_ctrl
// Directed bench for ber_sweep_ctrl with SETTLE_CYC=4, WINDOW_CYC=16.
// A small link model drives RECV_CNT/ERR_CNT; per-configuration expectations
// and end-of-sweep results are queued when a sweep is started and popped when
// the DUT emits CLR_SEQ pulses or raises DONE.
module tb_ber_sweep_ctrl;

  localparam int SETTLE = 4;
  localparam int WINDOW = 16;
  localparam int PERIOD = 2 + SETTLE + WINDOW;

  logic        clk;
  logic        rstx;
  logic        start;
  logic        abort_p;
  logic [30:0] base_ctrl;
  logic [15:0] err_thr;
  logic [57:0] recv_cnt;
  logic [63:0] err_cnt;
  logic [30:0] ctrl;
  logic        clr_seq;
  logic        busy;
  logic        done;
  logic [3:0]  cfg_idx;
  logic [15:0] pass_map;
  logic [3:0]  best_idx;
  logic [63:0] best_err;

  ber_sweep_ctrl #(
    .SETTLE_CYC(SETTLE),
    .WINDOW_CYC(WINDOW),
    .CNT_W(21)
  ) dut (
    .CLK(clk),
    .RSTX(rstx),
    .START(start),
    .ABORT(abort_p),
    .BASE_CTRL(base_ctrl),
    .ERR_THR(err_thr),
    .RECV_CNT(recv_cnt),
    .ERR_CNT(err_cnt),
    .CTRL(ctrl),
    .CLR_SEQ(clr_seq),
    .BUSY(busy),
    .DONE(done),
    .CFG_IDX(cfg_idx),
    .PASS_MAP(pass_map),
    .BEST_IDX(best_idx),
    .BEST_ERR(best_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Link model modes: 0 clean, 1 errors while DRV_STR_A==0,
  // 2 dead link on configuration 7, 3 error counter wrap on configuration 5
  int mode = 0;
  int tc   = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [30:0] word;
  } cfg_exp_t;

  typedef struct {
    logic [15:0] pm;
    logic [3:0]  bi;
    logic [63:0] be;
  } res_exp_t;

  cfg_exp_t cq[$];
  res_exp_t rq[$];

  always @(negedge clk) begin
    if (clr_seq) tc = 0;
    else tc = tc + 1;
    if (!(mode == 2 && busy && cfg_idx == 4'd7)) recv_cnt = recv_cnt + 58'd1;
    if (mode == 1 && ctrl[18:17] == 2'b00) err_cnt = err_cnt + 64'd1;
    if (mode == 3 && busy && cfg_idx == 4'd5) begin
      if (clr_seq) err_cnt = 64'hFFFF_FFFF_FFFF_FFFD;
      else if (tc >= 5 && tc <= 9) err_cnt = err_cnt + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] exp_word(input logic [30:0] b, input logic [3:0] i);
    logic [30:0] w;
    w = b;
    w[24:23] = i[1:0];
    w[18:17] = i[3:2];
    return w;
  endfunction

  task automatic push_sweep(input logic [30:0] b, input int ncfg,
                            input logic [15:0] pm, input logic [3:0] bi,
                            input logic [63:0] be);
    cfg_exp_t c;
    res_exp_t r;
    for (int i = 0; i < ncfg; i++) begin
      c.idx  = 4'(i);
      c.word = exp_word(b, 4'(i));
      cq.push_back(c);
    end
    r.pm = pm;
    r.bi = bi;
    r.be = be;
    rq.push_back(r);
  endtask

  task automatic pop_clr(input string tag);
    cfg_exp_t c;
    if (cq.size() == 0) begin
      check({tag, "_unexpected_clr"}, 64'd1, 64'd0);
    end else begin
      c = cq.pop_front();
      $display("clr_seq %s cfg_idx=%0d ctrl=%h", tag, cfg_idx, ctrl);
      check({tag, "_cfg_idx"}, 64'(cfg_idx), 64'(c.idx));
      check({tag, "_ctrl"}, 64'(ctrl), 64'(c.word));
    end
  endtask

  // Full sweep: START, then follow CLR_SEQ pulses until DONE (bounded).
  // poke >= 0 drives a stray START at that cycle, which must be ignored.
  task automatic run_sweep(input string tag, input int poke);
    int cycles;
    int last_clr;
    int n_clr;
    res_exp_t r;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    last_clr = 0;
    n_clr = 0;
    check({tag, "_done_cleared"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cycles < 2000) begin
      if (clr_seq) begin
        pop_clr(tag);
        if (n_clr > 0) check({tag, "_clr_spacing"}, 64'(cycles - last_clr), 64'(PERIOD));
        last_clr = cycles;
        n_clr++;
      end
      start = (cycles == poke);
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    check({tag, "_done_latency"}, 64'(cycles), 64'(16 * PERIOD));
    check({tag, "_clr_count"}, 64'(n_clr), 64'd16);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_ctrl_end"}, 64'(ctrl), 64'(base_ctrl));
    if (rq.size() == 0) begin
      check({tag, "_no_result"}, 64'd1, 64'd0);
    end else begin
      r = rq.pop_front();
      $display("sweep %s pass_map=%h best_idx=%0d best_err=%0h", tag, pass_map, best_idx, best_err);
      check({tag, "_pass_map"}, 64'(pass_map), 64'(r.pm));
      check({tag, "_best_idx"}, 64'(best_idx), 64'(r.bi));
      check({tag, "_best_err"}, best_err, r.be);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 64'(ctrl), 64'd0);
    check({tag, "_clr_seq"}, 64'(clr_seq), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cfg_idx"}, 64'(cfg_idx), 64'd0);
    check({tag, "_pass_map"}, 64'(pass_map), 64'd0);
    check({tag, "_best_idx"}, 64'(best_idx), 64'd0);
    check({tag, "_best_err"}, best_err, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  // Wait (bounded) for the CLR_SEQ of configuration idx, popping each pulse.
  task automatic wait_clr(input string tag, input logic [3:0] idx);
    int guard;
    guard = 0;
    while (!(clr_seq && cfg_idx == idx) && guard < 1000) begin
      if (clr_seq) pop_clr(tag);
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) check({tag, "_wait_timeout"}, 64'd1, 64'd0);
    else pop_clr(tag);
  endtask

  initial begin
    rstx      = 1'b0;
    start     = 1'b0;
    abort_p   = 1'b0;
    base_ctrl = 31'h7FFF_FFFF;
    err_thr   = 16'd0;
    recv_cnt  = 58'd0;
    err_cnt   = 64'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rstx = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ctrl_follows_base", 64'(ctrl), 64'(base_ctrl));

    // 1: clean link
    mode = 0;
    err_thr = 16'd0;
    push_sweep(base_ctrl, 16, 16'hFFFF, 4'd0, 64'd0);
    run_sweep("clean", -1);

    // 2: errors only while DRV_STR_A==0, stray START mid-sweep
    mode = 1;
    base_ctrl = 31'h0000_0000;
    err_thr = 16'd5;
    push_sweep(base_ctrl, 16, 16'hFFF0, 4'd4, 64'd0);
    run_sweep("errmodel", 100);

    // 3: dead link on configuration 7
    mode = 2;
    base_ctrl = 31'h2A5A_C3C3;
    err_thr = 16'd0;
    push_sweep(base_ctrl, 16, 16'hFF7F, 4'd0, 64'd0);
    run_sweep("deadlink", -1);

    // 4: ERR_CNT wrap on configuration 5, RECV_CNT wraps during the sweep
    mode = 3;
    base_ctrl = 31'h1234_5678;
    err_thr = 16'd4;
    err_cnt = 64'd0;
    recv_cnt = 58'h3FF_FFFF_FFFF_FF00;
    push_sweep(base_ctrl, 16, 16'hFFDF, 4'd0, 64'd0);
    run_sweep("wrap", -1);

    // 5: ABORT in MEASURE of configuration 3, simultaneous START ignored
    mode = 0;
    base_ctrl = 31'h5555_AAAA;
    err_thr = 16'd0;
    push_sweep(base_ctrl, 4, 16'h0, 4'd0, 64'd0);
    void'(rq.pop_back());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_clr("abort", 4'd3);
    repeat (10) @(posedge clk);
    #1;
    abort_p = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort_p = 1'b0;
    start = 1'b0;
    $display("abort busy=%0d done=%0d pass_map=%h cfg_idx=%0d", busy, done, pass_map, cfg_idx);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_clr_seq", 64'(clr_seq), 64'd0);
    check("abort_ctrl", 64'(ctrl), 64'(base_ctrl));
    check("abort_pass_map", 64'(pass_map), 64'h0007);
    check("abort_cfg_idx", 64'(cfg_idx), 64'd3);
    check("abort_best_err", best_err, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start_ignored_busy", 64'(busy), 64'd0);
    check("abort_start_ignored_clr", 64'(clr_seq), 64'd0);
    check("abort_queue_empty", 64'(cq.size()), 64'd0);

    // 6: asynchronous reset mid-SETTLE, then a full sweep
    push_sweep(base_ctrl, 3, 16'h0, 4'd0, 64'd0);
    void'(rq.pop_back());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_clr("arst", 4'd2);
    repeat (2) @(posedge clk);
    #2;
    rstx = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    rstx = 1'b1;
    cq.delete();
    push_sweep(base_ctrl, 16, 16'hFFFF, 4'd0, 64'd0);
    run_sweep("after_arst", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
